// File: rtl/irq_dispatch_pkg.sv
// Shared types and constants for the interrupt dispatch sequencer.
package irq_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_MASK_WR  = 3'd1,
    ST_IDLE     = 3'd2,
    ST_RD_SEL   = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DISPATCH = 3'd5,
    ST_CLEAR    = 3'd6,
    ST_SPUR     = 3'd7
  } state_e;

  // Saturation ceiling of the spurious-read counter.
  localparam logic [7:0] SPUR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin finder: returns the first set bit of req,
// searching upward from start and wrapping past DATA_WIDTH-1 to 0.
module rr_priority_pick #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [ID_WIDTH-1:0]   start,
  output logic [ID_WIDTH-1:0]   gnt_id,
  output logic                  any
);

  // (base + off) mod DATA_WIDTH, valid for off < DATA_WIDTH.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(DATA_WIDTH)) sum = sum - 32'(DATA_WIDTH);
    return sum[ID_WIDTH-1:0];
  endfunction

  // req rotated so that bit 0 of rot is the bit at index start.
  logic [DATA_WIDTH-1:0] rot;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rot
    assign rot[gi] = req[wrap_add(start, gi)];
  end

  logic [ID_WIDTH-1:0] first_off;

  // Lowest set offset in the rotated vector, then rotate back to an index.
  always_comb begin
    first_off = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) first_off = ID_WIDTH'(i);
    end
    gnt_id = wrap_add(start, 32'(first_off));
    any    = |req;
  end

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Interrupt dispatch sequencer: owns the edge-capture register block port,
// programs its mask, reads pending sources, hands one index at a time to a
// consumer in round-robin order and clears exactly the dispatched bit.
module irq_dispatch_ctrl
  import irq_dispatch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = $clog2(DATA_WIDTH),
  parameter logic [DATA_WIDTH-1:0] MASK_RESET = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  irq_in,
  input  logic [DATA_WIDTH-1:0] rb_read_data,
  output logic                  rb_write,
  output logic                  rb_address_decode,
  output logic                  rb_irq_mask_reg_en,
  output logic                  rb_edge_capture_reg_en,
  output logic [DATA_WIDTH-1:0] rb_write_data,
  input  logic                  cfg_mask_wr,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  output logic                  vec_valid,
  output logic [ID_WIDTH-1:0]   vec_id,
  input  logic                  vec_ready,
  output logic                  busy,
  output logic [7:0]            spurious_cnt
);

  localparam logic [ID_WIDTH-1:0]   LAST_ID_RESET = ID_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONE           = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  cfg_pend_q, cfg_pend_d;
  logic [DATA_WIDTH-1:0] cfg_val_q, cfg_val_d;
  logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
  logic [ID_WIDTH-1:0]   vec_id_q, vec_id_d;
  logic                  vec_valid_q, vec_valid_d;
  logic                  busy_q, busy_d;
  logic [7:0]            spur_cnt_q, spur_cnt_d;
  logic                  rb_write_q, rb_write_d;
  logic                  rb_addr_q, rb_addr_d;
  logic                  rb_mask_en_q, rb_mask_en_d;
  logic                  rb_cap_en_q, rb_cap_en_d;
  logic [DATA_WIDTH-1:0] rb_wdata_q, rb_wdata_d;

  logic [DATA_WIDTH-1:0] pend;
  logic [ID_WIDTH-1:0]   rr_start;
  logic [ID_WIDTH-1:0]   pick_id;
  logic                  pick_any;

  // Only unmasked pending bits compete; the search begins just past the last
  // source served so every source gets its turn.
  assign pend     = rb_read_data & mask_q;
  assign rr_start = (last_id_q == LAST_ID_RESET) ? '0 : last_id_q + 1'b1;

  rr_priority_pick #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_pick (
    .req    (pend),
    .start  (rr_start),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Next-state logic; all outputs are decoded from the next state so they
  // come straight from flops and drop together on reset.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cfg_pend_d = cfg_pend_q;
    cfg_val_d  = cfg_val_q;
    last_id_d  = last_id_q;
    vec_id_d   = vec_id_q;
    spur_cnt_d = spur_cnt_q;

    case (state_q)
      ST_INIT: begin
        mask_d  = MASK_RESET;
        state_d = ST_MASK_WR;
      end
      ST_MASK_WR: state_d = ST_IDLE;
      ST_IDLE: begin
        // A pending mask update outranks a new interrupt.
        if (cfg_pend_q) begin
          mask_d     = cfg_val_q;
          cfg_pend_d = 1'b0;
          state_d    = ST_MASK_WR;
        end else if (irq_in) begin
          state_d = ST_RD_SEL;
        end
      end
      ST_RD_SEL: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!pick_any) begin
          state_d = ST_SPUR;
        end else begin
          vec_id_d = pick_id;
          state_d  = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (vec_ready) begin
          last_id_d = vec_id_q;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_SPUR: begin
        if (spur_cnt_q != SPUR_CNT_MAX) spur_cnt_d = spur_cnt_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // A new request lands after any IDLE consumption, so a request arriving
    // in that same cycle is kept for the next pass (last writer wins).
    if (cfg_mask_wr) begin
      cfg_pend_d = 1'b1;
      cfg_val_d  = cfg_mask;
    end

    vec_valid_d  = (state_d == ST_DISPATCH);
    busy_d       = (state_d != ST_IDLE);
    rb_write_d   = (state_d == ST_MASK_WR) || (state_d == ST_CLEAR);
    rb_addr_d    = rb_write_d;
    rb_mask_en_d = (state_d == ST_MASK_WR);
    rb_cap_en_d  = (state_d == ST_RD_SEL) || (state_d == ST_RD_WAIT) ||
                   (state_d == ST_CLEAR);
    rb_wdata_d   = '0;
    if (state_d == ST_MASK_WR)  rb_wdata_d = mask_d;
    else if (state_d == ST_CLEAR) rb_wdata_d = ONE << vec_id_d;
  end

  // State and registered outputs; reset returns to INIT with all outputs low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      mask_q       <= '0;
      cfg_pend_q   <= 1'b0;
      cfg_val_q    <= '0;
      last_id_q    <= LAST_ID_RESET;
      vec_id_q     <= '0;
      vec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      spur_cnt_q   <= '0;
      rb_write_q   <= 1'b0;
      rb_addr_q    <= 1'b0;
      rb_mask_en_q <= 1'b0;
      rb_cap_en_q  <= 1'b0;
      rb_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cfg_pend_q   <= cfg_pend_d;
      cfg_val_q    <= cfg_val_d;
      last_id_q    <= last_id_d;
      vec_id_q     <= vec_id_d;
      vec_valid_q  <= vec_valid_d;
      busy_q       <= busy_d;
      spur_cnt_q   <= spur_cnt_d;
      rb_write_q   <= rb_write_d;
      rb_addr_q    <= rb_addr_d;
      rb_mask_en_q <= rb_mask_en_d;
      rb_cap_en_q  <= rb_cap_en_d;
      rb_wdata_q   <= rb_wdata_d;
    end
  end

  assign rb_write               = rb_write_q;
  assign rb_address_decode      = rb_addr_q;
  assign rb_irq_mask_reg_en     = rb_mask_en_q;
  assign rb_edge_capture_reg_en = rb_cap_en_q;
  assign rb_write_data          = rb_wdata_q;
  assign vec_valid              = vec_valid_q;
  assign vec_id                 = vec_id_q;
  assign busy                   = busy_q;
  assign spurious_cnt           = spur_cnt_q;

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Bench for irq_dispatch_ctrl: a behavioural edge-capture register block,
// directed stimulus, and a scoreboard monitor for vectors and register writes.
module tb_irq_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        irq_in;
  logic [31:0] rb_read_data;
  logic        rb_write, rb_address_decode, rb_irq_mask_reg_en, rb_edge_capture_reg_en;
  logic [31:0] rb_write_data;
  logic        cfg_mask_wr;
  logic [31:0] cfg_mask;
  logic        vec_valid;
  logic [4:0]  vec_id;
  logic        vec_ready;
  logic        busy;
  logic [7:0]  spurious_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  vec_q[$];   // expected dispatched ids
  logic [32:0] wr_q[$];    // expected writes {is_mask, data}

  // Register block model
  logic [31:0] cap_m  = '0;
  logic [31:0] mask_m = '0;
  logic [31:0] rd_q   = '0;
  logic [31:0] cap_set;
  logic        force_irq;

  always #5 clk = ~clk;

  irq_dispatch_ctrl dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .irq_in                 (irq_in),
    .rb_read_data           (rb_read_data),
    .rb_write               (rb_write),
    .rb_address_decode      (rb_address_decode),
    .rb_irq_mask_reg_en     (rb_irq_mask_reg_en),
    .rb_edge_capture_reg_en (rb_edge_capture_reg_en),
    .rb_write_data          (rb_write_data),
    .cfg_mask_wr            (cfg_mask_wr),
    .cfg_mask               (cfg_mask),
    .vec_valid              (vec_valid),
    .vec_id                 (vec_id),
    .vec_ready              (vec_ready),
    .busy                   (busy),
    .spurious_cnt           (spurious_cnt)
  );

  always @(posedge clk) begin
    rd_q <= rb_edge_capture_reg_en ? cap_m : (rb_irq_mask_reg_en ? mask_m : 32'h0);
    if (rb_write && rb_address_decode && rb_irq_mask_reg_en) mask_m <= rb_write_data;
    cap_m <= (cap_m & ~((rb_write && rb_address_decode && rb_edge_capture_reg_en) ?
                        rb_write_data : 32'h0)) | cap_set;
  end

  assign rb_read_data = rd_q;
  assign irq_in       = (|(cap_m & mask_m)) | force_irq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rb_write) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 64'({rb_irq_mask_reg_en, rb_write_data}), 64'h1_DEAD_BEEF);
      end else begin
        logic [32:0] e;
        e = wr_q.pop_front();
        check("rb_write", 64'({rb_address_decode, rb_irq_mask_reg_en, rb_edge_capture_reg_en, rb_write_data}),
              64'({1'b1, e[32], ~e[32], e[31:0]}));
        $display("write mask_en=%0b data=%08h", rb_irq_mask_reg_en, rb_write_data);
      end
    end
    if (vec_valid && vec_ready) begin
      if (vec_q.size() == 0) begin
        check("unexpected_vec", 64'(vec_id), 64'hFF);
      end else begin
        logic [4:0] ev;
        ev = vec_q.pop_front();
        check("vec_id", 64'(vec_id), 64'(ev));
        $display("vec handshake id=%0d", vec_id);
      end
    end
    if (rb_irq_mask_reg_en && rb_edge_capture_reg_en)
      check("en_exclusive", 64'({rb_irq_mask_reg_en, rb_edge_capture_reg_en}), 64'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!vec_valid && n < 50) begin
      tick();
      n++;
    end
    check("vec_valid_seen", 64'(vec_valid), 64'h1);
  endtask

  task automatic serve();
    vec_ready = 1'b1;
    wait_valid();
    tick();
    vec_ready = 1'b0;
    tick();
  endtask

  task automatic pulse_cap(input logic [31:0] bits);
    cap_set = bits;
    tick();
    cap_set = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    reset_n = 1'b0; vec_ready = 1'b0; cfg_mask_wr = 1'b0; cfg_mask = '0;
    cap_set = '0; force_irq = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'({vec_valid, rb_write, rb_address_decode, rb_irq_mask_reg_en,
                                rb_edge_capture_reg_en, busy}), 64'h0);
    check("reset_vec_id", 64'(vec_id), 64'h0);
    check("reset_spur", 64'(spurious_cnt), 64'h0);

    // Reset release: one mask write of all ones, then idle
    wr_q.push_back({1'b1, 32'hFFFF_FFFF});
    reset_n = 1'b1;
    tick();
    check("init_mask_strobe", 64'({rb_write, rb_irq_mask_reg_en, rb_edge_capture_reg_en}), 64'h6);
    tick();
    check("idle_after_init", 64'({rb_write, busy}), 64'h0);
    tick();

    // Single source: latency and clear timing
    vec_q.push_back(5'd4);
    wr_q.push_back({1'b0, 32'h0000_0010});
    pulse_cap(32'h0000_0010);            // now in cycle t
    tick(); check("lat_t1_valid", 64'(vec_valid), 64'h0);
    check("lat_t1_rdsel", 64'({rb_edge_capture_reg_en, rb_write}), 64'h2);
    tick(); check("lat_t2_valid", 64'(vec_valid), 64'h0);
    tick(); check("lat_t3_valid", 64'({vec_valid, vec_id}), 64'({1'b1, 5'd4}));
    tick();
    tick(); vec_ready = 1'b1;             // cycle t+5
    tick(); vec_ready = 1'b0;             // cycle t+6
    check("clear_t6", 64'({rb_write, rb_write_data}), 64'({1'b1, 32'h10}));
    tick();
    check("irq_cleared", 64'({irq_in, busy}), 64'h0);

    // Round-robin wrap, starting from a fresh last_id
    wr_q.push_back({1'b1, 32'hFFFF_FFFF});
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    vec_q.push_back(5'd0);  wr_q.push_back({1'b0, 32'h0000_0001});
    vec_q.push_back(5'd31); wr_q.push_back({1'b0, 32'h8000_0000});
    pulse_cap(32'h8000_0001);
    serve(); serve();
    repeat (3) tick();
    vec_q.push_back(5'd0);  wr_q.push_back({1'b0, 32'h0000_0001});
    vec_q.push_back(5'd31); wr_q.push_back({1'b0, 32'h8000_0000});
    pulse_cap(32'h8000_0001);
    serve(); serve();
    repeat (3) tick();

    // Two mask requests during DISPATCH: only the last is written, after CLEAR
    vec_q.push_back(5'd2);
    wr_q.push_back({1'b0, 32'h0000_0004});
    wr_q.push_back({1'b1, 32'h0000_000F});
    pulse_cap(32'h0000_0004);
    wait_valid();
    cfg_mask_wr = 1'b1; cfg_mask = 32'h0000_00F0;
    tick();
    cfg_mask = 32'h0000_000F;
    tick();
    cfg_mask_wr = 1'b0;
    check("still_dispatch", 64'(vec_valid), 64'h1);
    serve();
    repeat (4) tick();

    // Masked sources stay pending; an unmasked one is served alone
    pulse_cap(32'h0000_0030);
    repeat (5) tick();
    check("masked_no_dispatch", 64'({vec_valid, busy}), 64'h0);
    vec_q.push_back(5'd1);
    wr_q.push_back({1'b0, 32'h0000_0002});
    pulse_cap(32'h0000_0002);
    serve();
    repeat (3) tick();
    check("masked_bits_kept", 64'(cap_m), 64'h30);

    // Spurious reads: counter saturates, nothing dispatched
    force_irq = 1'b1;
    repeat (4) tick();
    check("spur_first", 64'(spurious_cnt), 64'h1);
    vcount = 0;
    for (int i = 0; i < 1300; i++) begin
      tick();
      if (vec_valid) vcount++;
    end
    force_irq = 1'b0;
    repeat (6) tick();
    check("spur_saturated", 64'(spurious_cnt), 64'hFF);
    check("spur_no_vec", 64'(vcount), 64'h0);

    // Reopen the mask: held-back sources 4 and 5 are served in turn
    wr_q.push_back({1'b1, 32'hFFFF_FFFF});
    vec_q.push_back(5'd4); wr_q.push_back({1'b0, 32'h0000_0010});
    vec_q.push_back(5'd5); wr_q.push_back({1'b0, 32'h0000_0020});
    cfg_mask_wr = 1'b1; cfg_mask = 32'hFFFF_FFFF;
    tick();
    cfg_mask_wr = 1'b0;
    serve(); serve();
    repeat (3) tick();

    // Reset during DISPATCH: outputs drop at once, same id re-dispatched
    pulse_cap(32'h0000_0080);
    wait_valid();
    check("pre_reset_id", 64'(vec_id), 64'h7);
    reset_n = 1'b0;
    #1;
    check("async_drop", 64'({vec_valid, rb_write, rb_address_decode, rb_irq_mask_reg_en,
                             rb_edge_capture_reg_en, busy}), 64'h0);
    check("reset_spur_clr", 64'(spurious_cnt), 64'h0);
    vec_q.push_back(5'd7);
    wr_q.push_back({1'b1, 32'hFFFF_FFFF});
    wr_q.push_back({1'b0, 32'h0000_0080});
    tick(); tick();
    reset_n = 1'b1;
    serve();
    repeat (4) tick();

    check("vec_q_drained", 64'(vec_q.size()), 64'h0);
    check("wr_q_drained", 64'(wr_q.size()), 64'h0);
    check("capture_empty", 64'(cap_m), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
